// File: rtl/obi_mem_responder_pkg.sv
// Shared types and constants for the OBI memory responder.
// The response entry carries the read data, the error flag and the remaining-latency timer.
package obi_mem_responder_pkg;

   localparam int CNT_W = 4;

   // Fibonacci feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   typedef struct packed {
      logic [31:0]      rdata;
      logic             err;
      logic [CNT_W-1:0] cnt;
   } resp_entry_t;

   function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
      return (c == '0) ? c : c - CNT_W'(1);
   endfunction

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI bus between a core port (master) and the memory responder (slave).
// Address phase: a request is accepted in the cycle where req and gnt are both high;
// req/addr/we/be/wdata must stay stable until then. Response phase: rvalid is a one-cycle
// pulse per accepted request, in accept order, with no back-pressure from the master.
interface obi_mem_responder_if;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_resp_fifo.sv
// In-order response FIFO; every slot's latency timer counts down (saturating at 0) each cycle.
// Pointers carry one extra bit so that full and empty can be told apart.
module obi_resp_fifo
   import obi_mem_responder_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  resp_entry_t push_entry,
   input  logic        pop,
   output resp_entry_t head,
   output logic        full,
   output logic        empty
);
   localparam int PW = $clog2(DEPTH);

   resp_entry_t slots [DEPTH];
   logic [PW:0] wptr;
   logic [PW:0] rptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) slots[i].cnt <= cnt_dec(slots[i].cnt);
         // a fresh push overrides the decrement of the slot it lands in
         if (push) begin
            slots[wptr[PW-1:0]] <= push_entry;
            wptr <= wptr + (PW+1)'(1);
         end
         if (pop) rptr <= rptr + (PW+1)'(1);
      end
   end

   assign head  = slots[rptr[PW-1:0]];
   assign empty = (wptr == rptr);
   assign full  = ((wptr ^ rptr) == {1'b1, {PW{1'b0}}});

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory responder: word array, grant/error decode, fixed-latency in-order responses.
// Optional random grant stalls and response holds are enabled by defining OBI_RESP_RAND_STALL_EN.
module obi_mem_responder
   import obi_mem_responder_pkg::*;
#(
   parameter int          ADDR_WIDTH = 20,
   parameter int          DEPTH      = 4,
   parameter int          LATENCY    = 1,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input logic                clk_i,
   input logic                rst_ni,
   obi_mem_responder_if.slave bus
);
   localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

   logic [31:0]         mem [WORDS];
   logic [ADDR_WIDTH-3:0] widx;
   logic                addr_err;
   logic                accept;
   logic                pop;
   logic                full;
   logic                empty;
   logic                stall;
   logic                hold;
   resp_entry_t         push_entry;
   resp_entry_t         head;

`ifdef OBI_RESP_RAND_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr <= LFSR_SEED;
      else         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_POLY)};
   end

   assign stall = (lfsr[1:0] == 2'b00);
   assign hold  = (lfsr[3:2] == 2'b00);
`else
   assign stall = 1'b0;
   assign hold  = 1'b0;
`endif

   assign widx     = bus.addr[ADDR_WIDTH-1:2];
   assign addr_err = |bus.addr[31:ADDR_WIDTH];
   assign bus.gnt  = rst_ni && bus.req && !full && !stall;
   assign accept   = bus.req && bus.gnt;

   // Access happens in the accept cycle, so later accepts see earlier writes
   always_ff @(posedge clk_i) begin
      if (accept && bus.we && !addr_err) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.be[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      push_entry       = '0;
      push_entry.err   = addr_err;
      push_entry.cnt   = CNT_W'(LATENCY - 1);
      push_entry.rdata = (bus.we || addr_err) ? 32'h0 : mem[widx];
   end

   obi_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .push       (accept),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (full),
      .empty      (empty)
   );

   // The response is the head slot itself; it leaves the FIFO at the end of its rvalid cycle
   assign pop        = !empty && (head.cnt == '0) && !hold;
   assign bus.rvalid = pop;
   assign bus.rdata  = pop ? head.rdata : 32'h0;
   assign bus.err    = pop && head.err;

endmodule
